// File: rtl/mult3_share_arbiter_pkg.sv
// Shared types and helpers for the shared 3-bit multiplier arbiter.
// State encoding and round-robin index arithmetic live here.
package mult3_pkg;

    localparam int W_OP   = 3;
    localparam int W_PROD = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int rr_add(input int idx, input int off, input int n);
        int s;
        s = idx + off;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return rr_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/multiplier_adder3.sv
// Combinational 3x3 unsigned array multiplier.
// Sum of three shifted partial products.
module multiplier_adder3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);

    logic [5:0] pp0;
    logic [5:0] pp1;
    logic [5:0] pp2;

    assign pp0 = {3'b000, a & {3{b[0]}}};
    assign pp1 = {2'b00, a & {3{b[1]}}, 1'b0};
    assign pp2 = {1'b0, a & {3{b[2]}}, 2'b00};
    assign p   = pp0 + pp1 + pp2;

endmodule

// File: rtl/mult3_share_arbiter.sv
// Round-robin sharing of one multiplier_adder3 among N_REQ requesters.
// Operands registered on grant, product registered before the response.
module mult3_share_arbiter
    import mult3_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int W       = W_OP,
    parameter  int MUL_LAT = 1,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-1:0]     rsp_p,
    input  logic               rsp_ready,
    output logic               busy
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           gnt_found;
    logic           hs;
    logic           calc_done;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] mul_p;

    // Descending scan so the candidate closest to rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDW'(rr_add(int'(rr_ptr), k, N_REQ));
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign hs        = |(req_ready & req_valid);
    assign calc_done = (state == ST_CALC) && (cnt == CW'(MUL_LAT - 1));

    always_comb begin
        state_nx  = state;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hs) state_nx = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (calc_done) state_nx = ST_RESP;
            end
            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            rsp_id <= '0;
            rsp_p  <= '0;
        end else begin
            if (hs) begin
                op_a   <= req_a[int'(gnt_idx)*W +: W];
                op_b   <= req_b[int'(gnt_idx)*W +: W];
                rsp_id <= gnt_idx;
                rr_ptr <= IDW'(rr_next(int'(gnt_idx), N_REQ));
                cnt    <= '0;
            end
            if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
                if (calc_done) rsp_p <= mul_p;
            end
        end
    end

    multiplier_adder3 u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

endmodule

// File: tb/tb_mult3_share_arbiter.sv
// Bench for mult3_share_arbiter: MUL_LAT=1 and MUL_LAT=3 instances
// checked each cycle against a transaction-level model.
module tb_mult3_share_arbiter;

    logic       clk = 1'b0;
    logic       rst        [2];
    logic [1:0] req_valid  [2];
    logic [5:0] req_a      [2];
    logic [5:0] req_b      [2];
    logic [1:0] req_ready  [2];
    logic       rsp_valid  [2];
    logic       rsp_id     [2];
    logic [5:0] rsp_p      [2];
    logic       rsp_ready  [2];
    logic       busy       [2];

    always #5 clk = ~clk;

    mult3_share_arbiter #(.N_REQ(2), .W(3), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_p(rsp_p[0]),
        .rsp_ready(rsp_ready[0]), .busy(busy[0])
    );

    mult3_share_arbiter #(.N_REQ(2), .W(3), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_p(rsp_p[1]),
        .rsp_ready(rsp_ready[1]), .busy(busy[1])
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a request is granted, then the response
    // appears exactly lat+1 cycles after the grant and holds until taken.
    typedef struct {
        int id;
        int p;
    } rsp_t;

    int         lat_cfg [2] = '{1, 3};
    bit         m_known [2] = '{0, 0};
    bit         m_idle  [2];
    int         m_rr    [2];
    int         m_due   [2];
    logic [5:0] m_p     [2];
    logic [5:0] m_pp    [2];
    logic       m_id    [2];
    rsp_t       log0    [$];
    int         id1_cnt3 = 0;

    function automatic int first_grant(input logic [1:0] v, input int rr);
        for (int k = 0; k < 2; k++) begin
            if (((v >> ((rr + k) % 2)) & 2'b01) != 2'b00) return (rr + k) % 2;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int         g;
        int         oa;
        int         ob;
        logic [1:0] e_rdy;
        logic       e_val;
        logic       e_busy;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (m_known[d]) begin
                e_rdy  = 2'b00;
                e_val  = 1'b0;
                e_busy = 1'b0;
                if (m_idle[d]) begin
                    g = first_grant(req_valid[d], m_rr[d]);
                    if (g >= 0 && !rst[d]) e_rdy = 2'(1 << g);
                end else begin
                    e_busy = 1'b1;
                    e_val  = (cyc >= m_due[d]);
                end
                chk($sformatf("req_ready[%0d]", d), req_ready[d], e_rdy);
                chk($sformatf("rsp_valid[%0d]", d), rsp_valid[d], e_val);
                chk($sformatf("busy[%0d]", d), busy[d], e_busy);
                chk($sformatf("rsp_p[%0d]", d), rsp_p[d], m_p[d]);
                chk($sformatf("rsp_id[%0d]", d), rsp_id[d], m_id[d]);
            end
            if (rst[d]) begin
                m_known[d] = 1'b1;
                m_idle[d]  = 1'b1;
                m_rr[d]    = 0;
                m_p[d]     = '0;
                m_id[d]    = 1'b0;
            end else if (m_known[d]) begin
                if (m_idle[d]) begin
                    g = first_grant(req_valid[d], m_rr[d]);
                    if (g >= 0) begin
                        oa = int'((req_a[d] >> (3 * g)) & 6'd7);
                        ob = int'((req_b[d] >> (3 * g)) & 6'd7);
                        m_idle[d] = 1'b0;
                        m_id[d]   = 1'(g);
                        m_rr[d]   = (g + 1) % 2;
                        m_pp[d]   = 6'(oa * ob);
                        m_due[d]  = cyc + lat_cfg[d] + 1;
                    end
                end else if (cyc >= m_due[d]) begin
                    if (rsp_ready[d]) begin
                        m_idle[d] = 1'b1;
                        if (d == 0) log0.push_back('{int'(m_id[d]), int'(m_p[d])});
                        if (d == 1 && m_id[d] == 1'b1) id1_cnt3++;
                    end
                end else if (cyc + 1 == m_due[d]) begin
                    m_p[d] = m_pp[d];
                end
            end
        end
    end

    task automatic step(input int d, output logic [1:0] acc);
        @(negedge clk);
        #1;
        acc = req_ready[d] & req_valid[d];
        @(posedge clk);
        #1;
        req_valid[d] = req_valid[d] & ~acc;
    endtask

    function automatic bit pending(input int d, input int i);
        return ((req_valid[d] >> i) & 2'b01) != 2'b00;
    endfunction

    task automatic raise(input int d, input int i, input int a, input int b);
        logic [5:0] msk;
        msk = 6'd7 << (3 * i);
        req_valid[d] = req_valid[d] | 2'(1 << i);
        req_a[d] = (req_a[d] & ~msk) | (6'(a) << (3 * i));
        req_b[d] = (req_b[d] & ~msk) | (6'(b) << (3 * i));
    endtask

    task automatic issue0(input logic [1:0] v, input int a0, input int b0,
                          input int a1, input int b1);
        logic [1:0] acc;
        req_a[0]     = {3'(a1), 3'(a0)};
        req_b[0]     = {3'(b1), 3'(b0)};
        req_valid[0] = v;
        for (int t = 0; t < 60 && req_valid[0] != 2'b00; t++) step(0, acc);
        chk("issue_accepted", req_valid[0], 2'b00);
    endtask

    task automatic wait_idle(input int d);
        logic [1:0] acc;
        for (int t = 0; t < 60 && busy[d] !== 1'b0; t++) step(d, acc);
        chk("idle_reached", busy[d], 1'b0);
    endtask

    task automatic drain(input int d);
        logic [1:0] acc;
        rsp_ready[d] = 1'b1;
        for (int t = 0; t < 100 && (req_valid[d] != 2'b00 || busy[d] !== 1'b0); t++)
            step(d, acc);
        chk("drained", {req_valid[d], busy[d]}, 3'b000);
    endtask

    task automatic expect_log(input int id, input int p);
        rsp_t r;
        chk("log_nonempty", log0.size() > 0, 1'b1);
        if (log0.size() > 0) begin
            r = log0.pop_front();
            chk("log_id", r.id, id);
            chk("log_p", r.p, p);
        end
    endtask

    task automatic seq_lat1();
        logic [1:0] acc;
        rst[0]       = 1'b1;
        req_valid[0] = 2'b11;
        req_a[0]     = '0;
        req_b[0]     = '0;
        rsp_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        #2;
        chk("t1_first_ready", req_ready[0], 2'b01);
        req_valid[0] = 2'b00;
        @(posedge clk);
        #1;
        issue0(2'b01, 7, 5, 0, 0);
        wait_idle(0);
        expect_log(0, 35);
        issue0(2'b10, 0, 0, 0, 4);
        wait_idle(0);
        expect_log(1, 0);
        issue0(2'b11, 6, 5, 6, 3);
        wait_idle(0);
        expect_log(0, 30);
        expect_log(1, 18);
        issue0(2'b11, 5, 5, 2, 6);
        wait_idle(0);
        expect_log(0, 25);
        expect_log(1, 12);
        rsp_ready[0] = 1'b0;
        issue0(2'b01, 3, 4, 0, 0);
        req_a[0]     = {3'd1, 3'd3};
        req_b[0]     = {3'd1, 3'd4};
        req_valid[0] = 2'b10;
        repeat (7) step(0, acc);
        chk("t4_valid", rsp_valid[0], 1'b1);
        chk("t4_p", rsp_p[0], 6'd12);
        chk("t4_ready", req_ready[0], 2'b00);
        chk("t4_busy", busy[0], 1'b1);
        rsp_ready[0] = 1'b1;
        step(0, acc);
        chk("t4_idle", busy[0], 1'b0);
        chk("t4_grant1", req_ready[0], 2'b10);
        issue0(2'b10, 3, 4, 1, 1);
        wait_idle(0);
        expect_log(0, 12);
        expect_log(1, 1);
        issue0(2'b01, 3, 3, 0, 0);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("t5_busy", busy[0], 1'b0);
        chk("t5_valid", rsp_valid[0], 1'b0);
        repeat (5) step(0, acc);
        chk("t5_no_rsp", log0.size(), 0);
        for (int c = 0; c < 400; c++) begin
            step(0, acc);
            for (int i = 0; i < 2; i++) begin
                if (!pending(0, i) && $urandom_range(0, 2) == 0)
                    raise(0, i, $urandom_range(0, 7), $urandom_range(0, 7));
            end
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
        end
        drain(0);
    endtask

    task automatic seq_lat3();
        logic [1:0] acc;
        int         k;
        rst[1]       = 1'b1;
        req_valid[1] = 2'b00;
        req_a[1]     = '0;
        req_b[1]     = '0;
        rsp_ready[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        k = 0;
        raise(1, 1, 0, 0);
        for (int t = 0; t < 3000 && k < 64; t++) begin
            step(1, acc);
            if (acc[1]) k++;
            if (!pending(1, 1) && k < 64) raise(1, 1, k / 8, k % 8);
            if (!pending(1, 0) && $urandom_range(0, 3) == 0)
                raise(1, 0, $urandom_range(0, 7), $urandom_range(0, 7));
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
        end
        drain(1);
        chk("t6_pairs", id1_cnt3, 64);
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        fork
            seq_lat1();
            seq_lat3();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
